// File: rtl/alu_exec_pkg.sv
// Shared definitions for the iterative execute-stage ALU: operation codes,
// FSM state type and operation-class helpers.
package alu_exec_pkg;

   localparam logic [3:0] OP_AND     = 4'b0000;
   localparam logic [3:0] OP_OR      = 4'b0001;
   localparam logic [3:0] OP_ADD     = 4'b0010;
   localparam logic [3:0] OP_SLL     = 4'b0011;
   localparam logic [3:0] OP_SRL     = 4'b0100;
   localparam logic [3:0] OP_SUB     = 4'b0101;
   localparam logic [3:0] OP_SRA     = 4'b0110;
   localparam logic [3:0] OP_SLT     = 4'b0111;
   localparam logic [3:0] OP_BEQ     = 4'b1000;
   localparam logic [3:0] OP_BNE     = 4'b1001;
   localparam logic [3:0] OP_BLT     = 4'b1010;
   localparam logic [3:0] OP_BGE     = 4'b1011;
   localparam logic [3:0] OP_XOR     = 4'b1100;
   localparam logic [3:0] OP_LUI     = 4'b1101;
   localparam logic [3:0] OP_SLTI    = 4'b1110;
   localparam logic [3:0] OP_ILLEGAL = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGE);
   endfunction

endpackage

// File: rtl/alu_iterative_exec_core.sv
// Pure combinational evaluator for every non-shift operation and the branch
// compare; shift codes return zero here and are resolved by the top.
module alu_comb_core
   import alu_exec_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [3:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  cond,
   output logic                  illegal
);

   logic lt_s;
   logic eq_s;

   assign lt_s = ($signed(a) < $signed(b));
   assign eq_s = (a == b);

   // Operation decode and evaluation
   always_comb begin
      result  = '0;
      cond    = 1'b0;
      illegal = 1'b0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_SLT,
         OP_SLTI: result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
         OP_LUI:  result = b;
         OP_BEQ:  cond = eq_s;
         OP_BNE:  cond = ~eq_s;
         OP_BLT:  cond = lt_s;
         OP_BGE:  cond = ~lt_s;
         OP_SLL,
         OP_SRL,
         OP_SRA:  result = '0;
         OP_ILLEGAL: illegal = 1'b1;
         default: illegal = 1'b1;
      endcase
      if (is_branch(op)) begin
         result = {{(DATA_WIDTH-1){1'b0}}, cond};
      end else begin
         result = result;
      end
   end

endmodule

// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU with valid/ready handshake and a 1-bit/cycle shifter.
// Define ALU_BARREL_SHIFT_EN to resolve shifts in a single cycle instead.
module alu_iterative_exec
   import alu_exec_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero,
   output logic                  BranchTaken,
   output logic                  IllegalOp
);

   state_t                  state_r;
   logic [SHAMT_W-1:0]      count_r;
   logic [DATA_WIDTH-1:0]   acc_r;
   logic [3:0]              op_r;
   logic [DATA_WIDTH-1:0]   result_r;
   logic                    zero_r;
   logic                    taken_r;
   logic                    illegal_r;
   logic                    out_valid_r;

   logic [SHAMT_W-1:0]      shamt_s;
   logic [DATA_WIDTH-1:0]   core_result_s;
   logic                    core_cond_s;
   logic                    core_illegal_s;
   logic [DATA_WIDTH-1:0]   shift_now_s;
   logic                    start_shift_s;
   logic [DATA_WIDTH-1:0]   accept_result_s;
   logic [DATA_WIDTH-1:0]   shift_step_s;

   assign shamt_s = SrcB[SHAMT_W-1:0];

   alu_comb_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .op      (Operation),
      .a       (SrcA),
      .b       (SrcB),
      .result  (core_result_s),
      .cond    (core_cond_s),
      .illegal (core_illegal_s)
   );

`ifdef ALU_BARREL_SHIFT_EN
   function automatic logic [DATA_WIDTH-1:0] barrel(input logic [3:0] op,
                                                    input logic [DATA_WIDTH-1:0] a,
                                                    input logic [SHAMT_W-1:0] sh);
      logic [DATA_WIDTH-1:0] r;
      case (op)
         OP_SLL:  r = a << sh;
         OP_SRL:  r = a >> sh;
         OP_SRA:  r = $signed(a) >>> sh;
         default: r = a;
      endcase
      return r;
   endfunction

   assign shift_now_s   = barrel(Operation, SrcA, shamt_s);
   assign start_shift_s = 1'b0;
`else
   // A zero shift amount leaves SrcA untouched and completes like any other op
   assign shift_now_s   = SrcA;
   assign start_shift_s = is_shift(Operation) && (shamt_s != '0);
`endif

   // Result captured on accept for everything that does not iterate
   always_comb begin
      accept_result_s = core_result_s;
      if (is_shift(Operation)) begin
         accept_result_s = shift_now_s;
      end else begin
         accept_result_s = core_result_s;
      end
   end

   // One-bit shift of the accumulator according to the latched operation
   always_comb begin
      shift_step_s = acc_r;
      case (op_r)
         OP_SLL:  shift_step_s = {acc_r[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  shift_step_s = {1'b0, acc_r[DATA_WIDTH-1:1]};
         OP_SRA:  shift_step_s = {acc_r[DATA_WIDTH-1], acc_r[DATA_WIDTH-1:1]};
         default: shift_step_s = acc_r;
      endcase
   end

   // Control FSM, shift iterator and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         count_r     <= '0;
         acc_r       <= '0;
         op_r        <= OP_AND;
         result_r    <= '0;
         zero_r      <= 1'b1;
         taken_r     <= 1'b0;
         illegal_r   <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  op_r  <= Operation;
                  acc_r <= SrcA;
                  if (start_shift_s) begin
                     count_r <= shamt_s;
                     state_r <= ST_SHIFT;
                  end else begin
                     result_r    <= accept_result_s;
                     zero_r      <= (accept_result_s == '0);
                     taken_r     <= core_cond_s;
                     illegal_r   <= core_illegal_s;
                     out_valid_r <= 1'b1;
                     state_r     <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               acc_r   <= shift_step_s;
               count_r <= count_r - SHAMT_W'(1);
               if (count_r == SHAMT_W'(1)) begin
                  result_r    <= shift_step_s;
                  zero_r      <= (shift_step_s == '0);
                  taken_r     <= 1'b0;
                  illegal_r   <= 1'b0;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = (state_r == ST_IDLE);
   assign out_valid   = out_valid_r;
   assign ALUResult   = result_r;
   assign Zero        = zero_r;
   assign BranchTaken = taken_r;
   assign IllegalOp   = illegal_r;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed self-checking bench for alu_iterative_exec (either shifter build).
module tb_alu_iterative_exec;
   import alu_exec_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        BranchTaken;
   logic        IllegalOp;

   int n_cmp = 0;
   int n_bad = 0;

   alu_iterative_exec dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .Operation   (Operation),
      .SrcA        (SrcA),
      .SrcB        (SrcB),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ALUResult   (ALUResult),
      .Zero        (Zero),
      .BranchTaken (BranchTaken),
      .IllegalOp   (IllegalOp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int shift_lat(input int shamt);
`ifdef ALU_BARREL_SHIFT_EN
      return 1;
`else
      return (shamt == 0) ? 1 : 1 + shamt;
`endif
   endfunction

   // Issue one op, scramble inputs after accept, measure latency, check, release.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                         input logic exp_bt, input logic exp_ill);
      int lat;
      int w;
      w = 0;
      while (in_ready !== 1'b1 && w < 100) begin
         @(posedge clk); #1; w++;
      end
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; Operation = OP_ILLEGAL; SrcA = ~a; SrcB = ~b;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, ALUResult, exp_res);
      chk({tag, "_zero"}, {31'd0, Zero}, {31'd0, (exp_res == 32'd0)});
      chk({tag, "_bt"}, {31'd0, BranchTaken}, {31'd0, exp_bt});
      chk({tag, "_ill"}, {31'd0, IllegalOp}, {31'd0, exp_ill});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      Operation = OP_AND; SrcA = 32'd0; SrcB = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", ALUResult, 32'd0);
      chk("rst_zero", {31'd0, Zero}, 32'd1);
      chk("rst_bt", {31'd0, BranchTaken}, 32'd0);
      chk("rst_ill", {31'd0, IllegalOp}, 32'd0);

      run_op("add_wrap", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 1'b0, 1'b0);
      run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 32'd0, 1, 1'b0, 1'b0);
      run_op("and", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, 1'b0, 1'b0);
      run_op("xor", OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1, 1'b0, 1'b0);
      run_op("sra31", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, shift_lat(31), 1'b0, 1'b0);
      run_op("srl31", OP_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, shift_lat(31), 1'b0, 1'b0);
      run_op("sll0", OP_SLL, 32'hA5A5_0F0F, 32'd0, 32'hA5A5_0F0F, shift_lat(0), 1'b0, 1'b0);
      run_op("sll4", OP_SLL, 32'h0000_00F1, 32'd4, 32'h0000_0F10, shift_lat(4), 1'b0, 1'b0);
      run_op("sll_hi", OP_SLL, 32'h0000_0001, 32'hFFFF_FFE1, 32'h0000_0002, shift_lat(1), 1'b0, 1'b0);
      run_op("blt", OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b1, 1'b0);
      run_op("bge", OP_BGE, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0, 1'b0);
      run_op("bne", OP_BNE, 32'd3, 32'd3, 32'd0, 1, 1'b0, 1'b0);
      run_op("beq", OP_BEQ, 32'd3, 32'd3, 32'd1, 1, 1'b1, 1'b0);

      // Backpressure: result held, second request ignored until released
      Operation = OP_SLT; SrcA = 32'hFFFF_FFFE; SrcB = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      Operation = OP_ADD; SrcA = 32'd10; SrcB = 32'd20;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_result", ALUResult, 32'd1);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_second_res", ALUResult, 32'd30);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset in the middle of a long shift discards it
      Operation = OP_SLL; SrcA = 32'd1; SrcB = 32'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_result", ALUResult, 32'd0);
      chk("mid_rst_zero", {31'd0, Zero}, 32'd1);
      repeat (25) @(posedge clk);
      #1 chk("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
      run_op("add_after_rst", OP_ADD, 32'd2, 32'd3, 32'd5, 1, 1'b0, 1'b0);

      run_op("illegal", OP_ILLEGAL, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1, 1'b0, 1'b1);
      run_op("lui", OP_LUI, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1, 1'b0, 1'b0);
      run_op("slti", OP_SLTI, 32'd3, 32'hFFFF_FFFF, 32'd0, 1, 1'b0, 1'b0);
      run_op("slt_neg", OP_SLT, 32'h8000_0000, 32'd0, 32'd1, 1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_iterative_exec.md
Name: alu_iterative_exec

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code emitted by the ALU controller, together with operands SrcA/SrcB.
- Single-cycle ops complete in one cycle; shifts run iteratively at 1 bit/cycle.
- Valid/ready handshake on both sides; the pipeline hazard unit stalls on in_ready low.
- Result is held on the output until the consumer accepts it.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount width taken from SrcB[SHAMT_W-1:0].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- Operation  in  4  ALU operation code (encoding below)
- SrcA  in  DATA_WIDTH  operand A
- SrcB  in  DATA_WIDTH  operand B / immediate / shamt
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- ALUResult  out  DATA_WIDTH  result
- Zero  out  1  ALUResult == 0
- BranchTaken  out  1  branch condition true (branch ops only)
- IllegalOp  out  1  unsupported code was executed

Behaviour:
- Encoding (shared package):
  - 0000 AND; 0001 OR; 0010 ADD; 0101 SUB; 1100 XOR
  - 0011 SLL; 0100 SRL; 0110 SRA
  - 0111 SLT (signed); 1110 SLTI (signed, same as SLT); 1101 LUI (result = SrcB)
  - 1000 BEQ; 1001 BNE; 1010 BLT (signed); 1011 BGE (signed)
  - 1111 illegal
- Branch ops: ALUResult = {0…, cond}; BranchTaken = cond. BranchTaken is 0 for all non-branch ops.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH, no overflow flag. SLT/SLTI result is 0 or 1, zero-extended.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch Operation/SrcA/SrcB.
  - Shift op with shamt ≠ 0: go to SHIFT with count = shamt and acc = SrcA.
  - Otherwise: compute the result and go to DONE.
- SHIFT:
  - Each cycle: acc shifts 1 bit (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill); count decrements.
  - When count reaches 1, the final shift is done and the FSM goes to DONE.
- DONE:
  - out_valid = 1; ALUResult/Zero/BranchTaken/IllegalOp stay stable.
  - On out_ready: go to IDLE. No same-cycle re-accept; in_ready rises the next cycle.
- Latency from accept edge T: out_valid at T+1 for non-shift ops and shamt = 0; at T+1+shamt for shifts. Worst case DATA_WIDTH cycles (shamt = 31).
- Throughput: one op per 2 cycles minimum, when out_ready is held high.
- in_valid while busy is ignored, not queued. The upstream stage must hold it.
- Operation/SrcA/SrcB changes after accept have no effect on the op in flight.
- Illegal op (1111): ALUResult = 0, Zero = 1, IllegalOp = 1, latency 1.
- Reset (any state, including mid-shift): state = IDLE, in_ready = 1, out_valid = 0, ALUResult = 0, Zero = 1, BranchTaken = 0, IllegalOp = 0, count = 0. The op in flight is discarded.
- Outputs are registered: no combinational path from in_* to out_*. The only exception is in_ready, which is a pure function of state.

Optional Feature:
- ALU_BARREL_SHIFT_EN defined: shifts are computed in one cycle like other ops, so latency is always 1 and the SHIFT state is never entered (may be compiled out).
- Undefined: iterative shifter as described above.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package alu_exec_pkg:
  - Operation-code localparams (OP_AND … OP_ILLEGAL).
  - FSM state enum typedef.
  - is_shift() and is_branch() helper functions.
- One natural sub-module: alu_comb_core, the pure combinational evaluator for all non-shift ops plus branch compare. It returns result, cond and illegal.
- The top block keeps the FSM, shift iterator and output registers.

Test Plan:
- ADD SrcA=0x7FFFFFFF, SrcB=1 → out_valid at T+1, ALUResult=0x80000000, Zero=0, BranchTaken=0; SUB 5-5 → 0, Zero=1.
- SRA SrcA=0x80000000, SrcB=31 → out_valid exactly at T+32 (T+1 with ALU_BARREL_SHIFT_EN), ALUResult=0xFFFFFFFF; SRL same operands → 0x00000001; SLL shamt=0 → SrcA unchanged, latency 1.
- BLT SrcA=0xFFFFFFFF (-1), SrcB=1 → BranchTaken=1, ALUResult=1; BGE same operands → BranchTaken=0; BNE 3,3 → 0; BEQ 3,3 → 1.
- Backpressure: SLT -2<1 with out_ready=0 for 5 cycles → out_valid/ALUResult=1 stable, in_ready=0, a second in_valid is ignored; out_ready=1 → IDLE next cycle, then the second op is accepted.
- reset asserted mid-SLL (shamt=20, after 7 cycles) → next edge IDLE, out_valid=0, ALUResult=0, Zero=1; new ADD 2+3 completes → 5.
- Operation=1111 → IllegalOp=1, ALUResult=0, latency 1; LUI SrcB=0x12345000 → 0x12345000; SLTI 3<-1 → 0.
